// File: rtl/mc_pkg.sv
// Shared constants for the multicycle sequencer: opcode/funct values,
// ALU function codes, next-PC select encodings and the FSM state type.
package mc_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_DIV   = 6'b011010;

  localparam logic [5:0] ALU_ADD  = 6'b100000;
  localparam logic [5:0] ALU_SUB  = 6'b100010;
  localparam logic [5:0] ALU_AND  = 6'b100100;
  localparam logic [5:0] ALU_OR   = 6'b100101;
  localparam logic [5:0] ALU_SLT  = 6'b101010;
  localparam logic [5:0] ALU_NOP  = 6'b000000;

  localparam logic [1:0] CP_SEQ    = 2'b00;
  localparam logic [1:0] CP_REG    = 2'b01;
  localparam logic [1:0] CP_JUMP   = 2'b10;
  localparam logic [1:0] CP_BRANCH = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_HALT
  } state_t;

  function automatic logic is_long_funct(input logic [5:0] fn);
    return (fn == FN_MULT) || (fn == FN_DIV);
  endfunction

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction classifier: turns the latched opcode/funct into
// the control attributes the sequencer FSM and datapath strobes need.
module mc_decode
  import mc_pkg::*;
#(
  parameter int OPW = 6,
  parameter int FW  = 6
) (
  input  logic [OPW-1:0] opcode,
  input  logic [FW-1:0]  funct,
  output logic           is_long,
  output logic           is_mem,
  output logic           is_store,
  output logic           is_halt,
  output logic           wr_reg,
  output logic           wr_lr,
  output logic [FW-1:0]  alu_func,
  output logic [1:0]     cp_type
);

  logic is_r;
  logic is_jr;
  logic is_branch;
  logic is_jump;
  logic is_imm_alu;

  assign is_r       = (opcode == OPW'(OP_RTYPE));
  assign is_jr      = is_r && (funct == FW'(FN_JR));
  assign is_branch  = (opcode == OPW'(OP_BEQ)) || (opcode == OPW'(OP_BNE));
  assign is_jump    = (opcode == OPW'(OP_J)) || (opcode == OPW'(OP_JAL));
  assign is_imm_alu = (opcode == OPW'(OP_ADDI)) || (opcode == OPW'(OP_ANDI)) ||
                      (opcode == OPW'(OP_ORI))  || (opcode == OPW'(OP_SLTI)) ||
                      (opcode == OPW'(OP_LUI));

  assign is_long  = is_r && ((funct == FW'(FN_MULT)) || (funct == FW'(FN_DIV)));
  assign is_mem   = (opcode == OPW'(OP_LW)) || (opcode == OPW'(OP_SW));
  assign is_store = (opcode == OPW'(OP_SW));
  assign is_halt  = (opcode == OPW'(OP_HALT));
  assign wr_lr    = (opcode == OPW'(OP_JAL));

  // Unknown opcodes fall through every term and retire as pure PC updates.
  assign wr_reg   = (is_r && !is_jr) || is_imm_alu || (opcode == OPW'(OP_LW));

  always_comb begin
    alu_func = FW'(ALU_NOP);
    if (is_r) begin
      alu_func = funct;
    end else if (opcode == OPW'(OP_ADDI)) begin
      alu_func = FW'(ALU_ADD);
    end else if (opcode == OPW'(OP_ANDI)) begin
      alu_func = FW'(ALU_AND);
    end else if (opcode == OPW'(OP_ORI)) begin
      alu_func = FW'(ALU_OR);
    end else if (opcode == OPW'(OP_SLTI)) begin
      alu_func = FW'(ALU_SLT);
    end else if (is_branch) begin
      alu_func = FW'(ALU_SUB);
    end
  end

  always_comb begin
    cp_type = CP_SEQ;
    if (is_jr || is_halt) begin
      cp_type = CP_REG;
    end else if (is_jump) begin
      cp_type = CP_JUMP;
    end else if (is_branch) begin
      cp_type = CP_BRANCH;
    end
  end

endmodule

// File: rtl/mc_sequencer.sv
// Multicycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB FSM with memory
// handshakes, long-op exec counter, req/ack watchdog and retired counter.
module mc_sequencer
  import mc_pkg::*;
#(
  parameter int OPW      = 6,
  parameter int FW       = 6,
  parameter int LONG_LAT = 4,
  parameter int TIMEOUT  = 255,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             stop,
  output logic             imem_req,
  input  logic             imem_ack,
  input  logic [OPW-1:0]   opcode_in,
  input  logic [FW-1:0]    funct_in,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ack,
  output logic             ir_load,
  output logic [FW-1:0]    alu_func,
  output logic [1:0]       cp_type,
  output logic             write_pc,
  output logic             write_reg,
  output logic             write_lr,
  output logic             busy,
  output logic             halted,
  output logic             fault,
  output logic [CNT_W-1:0] retired
);

  localparam int EXW = (LONG_LAT > 1) ? $clog2(LONG_LAT) : 1;
  localparam int WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  state_t           state_reg, state_next;
  logic [OPW-1:0]   opcode_reg;
  logic [FW-1:0]    funct_reg;
  logic [EXW-1:0]   exec_cnt_reg, exec_cnt_next;
  logic [WDW-1:0]   wd_cnt_reg, wd_cnt_next;
  logic             fault_reg, fault_next;
  logic [CNT_W-1:0] retired_reg;

  logic             dec_is_long;
  logic             dec_is_mem;
  logic             dec_is_store;
  logic             dec_is_halt;
  logic             dec_wr_reg;
  logic             dec_wr_lr;
  logic [FW-1:0]    dec_alu_func;
  logic [1:0]       dec_cp_type;

  logic             req_active;
  logic             ack_seen;
  logic             wd_expired;

  mc_decode #(
    .OPW (OPW),
    .FW  (FW)
  ) u_decode (
    .opcode   (opcode_reg),
    .funct    (funct_reg),
    .is_long  (dec_is_long),
    .is_mem   (dec_is_mem),
    .is_store (dec_is_store),
    .is_halt  (dec_is_halt),
    .wr_reg   (dec_wr_reg),
    .wr_lr    (dec_wr_lr),
    .alu_func (dec_alu_func),
    .cp_type  (dec_cp_type)
  );

  assign req_active = (state_reg == ST_FETCH) || (state_reg == ST_MEM);
  assign ack_seen   = ((state_reg == ST_FETCH) && imem_ack) ||
                      ((state_reg == ST_MEM) && dmem_ack);
  // The counter sits at TIMEOUT-1 during the TIMEOUT-th unanswered req cycle.
  assign wd_expired = (TIMEOUT != 0) && req_active && !ack_seen &&
                      (wd_cnt_reg == WDW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_reg    <= ST_IDLE;
      exec_cnt_reg <= '0;
      wd_cnt_reg   <= '0;
      fault_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      exec_cnt_reg <= exec_cnt_next;
      wd_cnt_reg   <= wd_cnt_next;
      fault_reg    <= fault_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      opcode_reg  <= '0;
      funct_reg   <= '0;
      retired_reg <= '0;
    end else begin
      if ((state_reg == ST_FETCH) && imem_ack) begin
        opcode_reg <= opcode_in;
        funct_reg  <= funct_in;
      end
      if (state_reg == ST_WB) begin
        retired_reg <= retired_reg + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_next    = state_reg;
    exec_cnt_next = exec_cnt_reg;
    wd_cnt_next   = '0;
    fault_next    = fault_reg;

    case (state_reg)
      ST_IDLE: begin
        if (start) state_next = ST_FETCH;
      end
      ST_FETCH: begin
        if (imem_ack) state_next = ST_DECODE;
      end
      ST_DECODE: begin
        if (dec_is_halt) begin
          state_next = ST_HALT;
        end else begin
          state_next    = ST_EXEC;
          exec_cnt_next = dec_is_long ? EXW'(LONG_LAT - 1) : '0;
        end
      end
      ST_EXEC: begin
        if (exec_cnt_reg != '0) begin
          exec_cnt_next = exec_cnt_reg - EXW'(1);
        end else begin
          state_next = dec_is_mem ? ST_MEM : ST_WB;
        end
      end
      ST_MEM: begin
        if (dmem_ack) state_next = ST_WB;
      end
      ST_WB: begin
        state_next = stop ? ST_IDLE : ST_FETCH;
      end
      ST_HALT: begin
        if (start) state_next = ST_FETCH;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    // Counter is zero on every entry to FETCH/MEM since all other states clear it.
    if (req_active && !ack_seen && (TIMEOUT != 0)) begin
      if (wd_expired) begin
        state_next = ST_HALT;
        fault_next = 1'b1;
      end else begin
        wd_cnt_next = wd_cnt_reg + WDW'(1);
      end
    end
  end

  always_comb begin
    imem_req  = 1'b0;
    ir_load   = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    write_pc  = 1'b0;
    write_reg = 1'b0;
    write_lr  = 1'b0;
    alu_func  = '0;
    cp_type   = CP_SEQ;
    busy      = (state_reg != ST_IDLE) && (state_reg != ST_HALT);
    halted    = (state_reg == ST_HALT);

    case (state_reg)
      ST_FETCH: begin
        imem_req = 1'b1;
        ir_load  = imem_ack;
      end
      ST_EXEC: begin
        alu_func = dec_alu_func;
        cp_type  = dec_cp_type;
      end
      ST_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = dec_is_store;
        alu_func = dec_alu_func;
        cp_type  = dec_cp_type;
      end
      ST_WB: begin
        write_pc  = 1'b1;
        write_reg = dec_wr_reg;
        write_lr  = dec_wr_lr;
        alu_func  = dec_alu_func;
        cp_type   = dec_cp_type;
      end
      default: begin
      end
    endcase
  end

  assign fault   = fault_reg;
  assign retired = retired_reg;

endmodule

// File: tb/tb_mc_sequencer.sv
// Randomized self-checking bench for mc_sequencer: each instruction's phase
// timeline and WB attributes are derived from the instruction-class rules.
module tb_mc_sequencer;

  localparam int LONG_LAT = 4;
  localparam int TIMEOUT  = 8;
  localparam int CNT_W    = 32;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             imem_ack = 1'b0;
  logic             dmem_ack = 1'b0;
  logic [5:0]       opcode_in = '0;
  logic [5:0]       funct_in = '0;
  logic             imem_req, dmem_req, dmem_we, ir_load;
  logic [5:0]       alu_func;
  logic [1:0]       cp_type;
  logic             write_pc, write_reg, write_lr, busy, halted, fault;
  logic [CNT_W-1:0] retired;

  int               checks = 0;
  int               errors = 0;
  logic [CNT_W-1:0] exp_retired = '0;

  always #5 clk = ~clk;

  mc_sequencer #(
    .OPW      (6),
    .FW       (6),
    .LONG_LAT (LONG_LAT),
    .TIMEOUT  (TIMEOUT),
    .CNT_W    (CNT_W)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .start     (start),
    .stop      (stop),
    .imem_req  (imem_req),
    .imem_ack  (imem_ack),
    .opcode_in (opcode_in),
    .funct_in  (funct_in),
    .dmem_req  (dmem_req),
    .dmem_we   (dmem_we),
    .dmem_ack  (dmem_ack),
    .ir_load   (ir_load),
    .alu_func  (alu_func),
    .cp_type   (cp_type),
    .write_pc  (write_pc),
    .write_reg (write_reg),
    .write_lr  (write_lr),
    .busy      (busy),
    .halted    (halted),
    .fault     (fault),
    .retired   (retired)
  );

  // Instruction attributes as listed by the instruction-set rules.
  typedef struct packed {
    bit         lng;
    bit         mem;
    bit         st;
    bit         wreg;
    bit         wlr;
    logic [5:0] alu;
    logic [1:0] cp;
  } ref_t;

  function automatic ref_t ref_of(input logic [5:0] op, input logic [5:0] fn);
    ref_t r;
    bit   rt = (op == 6'b000000);
    r      = '0;
    r.lng  = rt && (fn == 6'b011000 || fn == 6'b011010);
    r.mem  = (op == 6'b100011) || (op == 6'b101011);
    r.st   = (op == 6'b101011);
    r.wreg = (rt && fn != 6'b001000) ||
             (op inside {6'b001000, 6'b001100, 6'b001101, 6'b001010, 6'b001111, 6'b100011});
    r.wlr  = (op == 6'b000011);
    if (rt) r.alu = fn;
    else if (op == 6'b001000) r.alu = 6'b100000;
    else if (op == 6'b001100) r.alu = 6'b100100;
    else if (op == 6'b001101) r.alu = 6'b100101;
    else if (op == 6'b001010) r.alu = 6'b101010;
    else if (op == 6'b000100 || op == 6'b000101) r.alu = 6'b100010;
    else r.alu = 6'b000000;
    if (rt && fn == 6'b001000) r.cp = 2'b01;
    else if (op == 6'b000010 || op == 6'b000011) r.cp = 2'b10;
    else if (op == 6'b000100 || op == 6'b000101) r.cp = 2'b11;
    else r.cp = 2'b00;
    return r;
  endfunction

  // {imem_req, ir_load, dmem_req, dmem_we, write_pc, write_reg, write_lr, busy, halted}
  function automatic logic [8:0] obs_vec();
    return {imem_req, ir_load, dmem_req, dmem_we, write_pc, write_reg, write_lr, busy, halted};
  endfunction

  function automatic logic [11:0] pick_instr();
    logic [5:0] rf = 6'($urandom);
    case ($urandom_range(0, 20))
      0:  return {6'b000000, 6'b100000};
      1:  return {6'b000000, 6'b100010};
      2:  return {6'b000000, 6'b100100};
      3:  return {6'b000000, 6'b101010};
      4:  return {6'b000000, 6'b001000};
      5:  return {6'b000000, 6'b011000};
      6:  return {6'b000000, 6'b011010};
      7:  return {6'b000000, rf};
      8:  return {6'b001000, rf};
      9:  return {6'b001100, rf};
      10: return {6'b001101, rf};
      11: return {6'b001010, rf};
      12: return {6'b001111, rf};
      13: return {6'b100011, rf};
      14: return {6'b101011, rf};
      15: return {6'b000100, rf};
      16: return {6'b000101, rf};
      17: return {6'b000010, rf};
      18: return {6'b000011, rf};
      19: return {6'b010000, rf};
      default: return {6'b110001, rf};
    endcase
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Called in IDLE/HALT one step after an edge; leaves the DUT in FETCH.
  task automatic start_seq();
    start = 1'b1;
    cycle();
    start = 1'b0;
    checks++;
    if (imem_req !== 1'b1 || busy !== 1'b1 || halted !== 1'b0) begin
      errors++;
      $display("FAIL start_to_fetch got imem_req=%b busy=%b halted=%b expected 1 1 0",
               imem_req, busy, halted);
    end
  endtask

  // Runs one instruction starting in FETCH; di/dm are unanswered req cycles.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                           input int di, input int dm, input bit stp);
    ref_t       r        = ref_of(op, fn);
    int         exec_len = r.lng ? LONG_LAT : 1;
    int         mem_len  = r.mem ? dm + 1 : 0;
    int         mem0     = di + 2 + exec_len;
    int         wb       = mem0 + mem_len;
    logic [8:0] ev;
    logic [8:0] ov;
    for (int k = 0; k <= wb; k++) begin
      bit in_f = (k <= di);
      bit in_m = (k >= mem0) && (k < wb);
      imem_ack  = in_f ? (k == di) : 1'($urandom_range(0, 1));
      opcode_in = (k == di) ? op : 6'($urandom);
      funct_in  = (k == di) ? fn : 6'($urandom);
      dmem_ack  = in_m ? (k == wb - 1) : 1'($urandom_range(0, 1));
      stop      = (k == wb) ? stp : 1'($urandom_range(0, 1));
      start     = (k == wb && stp) ? 1'b1 : 1'($urandom_range(0, 1));
      ev = 9'b0_0000_0010;
      if (in_f) begin
        ev[8] = 1'b1;
        ev[7] = (k == di);
      end
      if (in_m) begin
        ev[6] = 1'b1;
        ev[5] = r.st;
      end
      if (k == wb) begin
        ev[4] = 1'b1;
        ev[3] = r.wreg;
        ev[2] = r.wlr;
      end
      #1;
      ov = obs_vec();
      checks++;
      if (ov !== ev) begin
        errors++;
        $display("FAIL strobes op=%b fn=%b cycle=%0d got=%b expected=%b", op, fn, k, ov, ev);
      end
      if (k == wb) begin
        checks++;
        if (alu_func !== r.alu || cp_type !== r.cp) begin
          errors++;
          $display("FAIL wb_alu_cp op=%b fn=%b got alu=%b cp=%b expected alu=%b cp=%b",
                   op, fn, alu_func, cp_type, r.alu, r.cp);
        end
      end
      cycle();
    end
    exp_retired = exp_retired + 1;
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    stop     = 1'b0;
    start    = 1'b0;
    checks++;
    if (retired !== exp_retired) begin
      errors++;
      $display("FAIL retired op=%b got=%0d expected=%0d", op, retired, exp_retired);
    end
    $display("instr op=%b fn=%b imem_wait=%0d dmem_wait=%0d stop=%0d cycles=%0d retired=%0d",
             op, fn, di, dm, stp, wb + 1, retired);
    if (stp) begin
      #1;
      checks++;
      if (obs_vec() !== 9'b0) begin
        errors++;
        $display("FAIL idle_after_stop got=%b expected=%b", obs_vec(), 9'b0);
      end
      cycle();
      start_seq();
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    cycle();
    cycle();
    checks++;
    if (obs_vec() !== 9'b0 || alu_func !== 6'b0 || cp_type !== 2'b0 ||
        fault !== 1'b0 || retired !== '0) begin
      errors++;
      $display("FAIL reset_state got vec=%b alu=%b cp=%b fault=%b retired=%0d expected all zero",
               obs_vec(), alu_func, cp_type, fault, retired);
    end
    rstn = 1'b1;
    cycle();
    checks++;
    if (obs_vec() !== 9'b0) begin
      errors++;
      $display("FAIL idle_hold got=%b expected=%b", obs_vec(), 9'b0);
    end
    $display("reset done");
    start_seq();
  endtask

  task automatic test_add();
    run_instr(6'b000000, 6'b100000, 0, 0, 1'b0);
  endtask

  task automatic test_lw_delay();
    run_instr(6'b100011, 6'b010101, 0, 3, 1'b0);
  endtask

  task automatic test_sw_beq_jal();
    run_instr(6'b101011, 6'b000000, 0, 0, 1'b0);
    run_instr(6'b000100, 6'b000000, 0, 0, 1'b0);
    run_instr(6'b000011, 6'b000000, 0, 0, 1'b0);
  endtask

  task automatic test_long();
    run_instr(6'b000000, 6'b011000, 0, 0, 1'b0);
    run_instr(6'b000000, 6'b011010, 2, 0, 1'b0);
  endtask

  task automatic test_ack_boundary();
    run_instr(6'b100011, 6'b000000, TIMEOUT - 1, TIMEOUT - 1, 1'b0);
    checks++;
    if (fault !== 1'b0) begin
      errors++;
      $display("FAIL ack_beats_timeout got fault=%b expected 0", fault);
    end
  endtask

  task automatic test_stop();
    run_instr(6'b001101, 6'b000000, 1, 0, 1'b1);
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      logic [11:0] ins = pick_instr();
      run_instr(ins[11:6], ins[5:0], $urandom_range(0, 6), $urandom_range(0, 6),
                ($urandom_range(0, 7) == 0));
    end
  endtask

  task automatic test_halt();
    imem_ack  = 1'b1;
    opcode_in = 6'b111111;
    funct_in  = 6'($urandom);
    #1;
    checks++;
    if (obs_vec() !== 9'b1_1000_0010) begin
      errors++;
      $display("FAIL halt_fetch got=%b expected=%b", obs_vec(), 9'b1_1000_0010);
    end
    cycle();
    imem_ack = 1'b0;
    #1;
    checks++;
    if (obs_vec() !== 9'b0_0000_0010) begin
      errors++;
      $display("FAIL halt_decode got=%b expected=%b", obs_vec(), 9'b0_0000_0010);
    end
    cycle();
    for (int i = 0; i < 3; i++) begin
      imem_ack = 1'($urandom_range(0, 1));
      dmem_ack = 1'($urandom_range(0, 1));
      stop     = 1'($urandom_range(0, 1));
      #1;
      checks++;
      if (obs_vec() !== 9'b0_0000_0001) begin
        errors++;
        $display("FAIL halted_hold cycle=%0d got=%b expected=%b", i, obs_vec(), 9'b0_0000_0001);
      end
      cycle();
    end
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    stop     = 1'b0;
    checks++;
    if (retired !== exp_retired) begin
      errors++;
      $display("FAIL halt_no_retire got=%0d expected=%0d", retired, exp_retired);
    end
    $display("halt instruction retired=%0d", retired);
    start_seq();
    run_instr(6'b001000, 6'b000000, 0, 0, 1'b0);
  endtask

  task automatic test_timeout();
    for (int i = 0; i < TIMEOUT; i++) begin
      imem_ack = 1'b0;
      dmem_ack = 1'($urandom_range(0, 1));
      #1;
      checks++;
      if (obs_vec() !== 9'b1_0000_0010) begin
        errors++;
        $display("FAIL timeout_req cycle=%0d got=%b expected=%b", i, obs_vec(), 9'b1_0000_0010);
      end
      cycle();
    end
    dmem_ack = 1'b0;
    checks++;
    if (obs_vec() !== 9'b0_0000_0001 || fault !== 1'b1) begin
      errors++;
      $display("FAIL timeout_halt got vec=%b fault=%b expected vec=%b fault=1",
               obs_vec(), fault, 9'b0_0000_0001);
    end
    $display("watchdog timeout fault=%b", fault);
    start_seq();
    checks++;
    if (fault !== 1'b1) begin
      errors++;
      $display("FAIL fault_sticky_start got=%b expected=1", fault);
    end
    run_instr(6'b000000, 6'b100101, 0, 0, 1'b0);
    checks++;
    if (fault !== 1'b1) begin
      errors++;
      $display("FAIL fault_sticky_run got=%b expected=1", fault);
    end
  endtask

  task automatic test_reset_in_mem();
    imem_ack  = 1'b1;
    opcode_in = 6'b100011;
    funct_in  = 6'b000000;
    cycle();
    imem_ack = 1'b0;
    cycle();
    cycle();
    dmem_ack = 1'b0;
    #1;
    checks++;
    if (obs_vec() !== 9'b0_0100_0010) begin
      errors++;
      $display("FAIL mem_reached got=%b expected=%b", obs_vec(), 9'b0_0100_0010);
    end
    rstn = 1'b0;
    cycle();
    checks++;
    if (obs_vec() !== 9'b0 || retired !== '0 || fault !== 1'b0 ||
        alu_func !== 6'b0 || cp_type !== 2'b0) begin
      errors++;
      $display("FAIL reset_in_mem got vec=%b retired=%0d fault=%b alu=%b cp=%b expected all zero",
               obs_vec(), retired, fault, alu_func, cp_type);
    end
    rstn = 1'b1;
    exp_retired = '0;
    $display("reset during mem retired=%0d fault=%b", retired, fault);
    cycle();
    start_seq();
    run_instr(6'b000000, 6'b100000, 0, 0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_add();
    test_lw_delay();
    test_sw_beq_jal();
    test_long();
    test_ack_boundary();
    test_stop();
    test_random();
    test_halt();
    test_timeout();
    test_reset_in_mem();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
